// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int ROWS_OF(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_func3.sv
// Example 3-input function swept by the controller: s = x'y'z + xyz'.
module tt_func3 (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s
);

  assign s = (~x & ~y & z) | (x & y & ~z);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: drives every input row in ascending order and captures f(row).
// Optional self-compare against an expected table is enabled by defining TT_SWEEP_COMPARE_EN.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [N_IN-1:0]              fx_in,
  input  logic                         fx_out,
  output logic                         busy,
  output logic                         row_valid,
  output logic [N_IN-1:0]              row_idx,
  output logic                         done,
`ifdef TT_SWEEP_COMPARE_EN
  output logic [ROWS_OF(N_IN)-1:0]     table_out,
  input  logic [ROWS_OF(N_IN)-1:0]     expected,
  output logic                         mismatch,
  output logic [N_IN:0]                mismatch_cnt
`else
  output logic [ROWS_OF(N_IN)-1:0]     table_out
`endif
);

  localparam int                ROWS     = ROWS_OF(N_IN);
  localparam logic [N_IN-1:0]   LAST_ROW = N_IN'(ROWS - 1);
  localparam logic [N_IN-1:0]   IDX_ONE  = N_IN'(1);

  state_t state, state_next;
  logic   accept;
  logic   last_row;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state plus the two decoded outputs; the function is only driven while sweeping.
  always_comb begin
    state_next = state;
    fx_in      = '0;
    row_valid  = 1'b0;
    accept     = (state == IDLE) && start;
    last_row   = (row_idx == LAST_ROW);
    case (state)
      IDLE:   if (start) state_next = DRIVE;
      DRIVE: begin
        fx_in      = row_idx;
        state_next = SAMPLE;
      end
      SAMPLE: begin
        fx_in      = row_idx;
        row_valid  = 1'b1;
        state_next = last_row ? DONE : DRIVE;
      end
      DONE:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          row_idx <= '0;
          if (start) begin
            table_out <= '0;
            busy      <= 1'b1;
          end
        end
        SAMPLE: begin
          table_out[row_idx] <= fx_out;
          if (last_row) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            row_idx <= row_idx + IDX_ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TT_SWEEP_COMPARE_EN
  localparam logic [N_IN:0] CNT_ONE = (N_IN+1)'(1);

  logic row_miss;
  assign row_miss = (fx_out != expected[row_idx]);

  // The final row's miss is folded in directly so mismatch is valid in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      mismatch_cnt <= '0;
      mismatch     <= 1'b0;
    end else if (state == SAMPLE) begin
      if (row_miss) mismatch_cnt <= mismatch_cnt + CNT_ONE;
      if (last_row) mismatch <= (mismatch_cnt != '0) || row_miss;
    end
  end
`endif

endmodule
